// File: rtl/vedic_mac_accumulator_if.sv
// Beat stream in, burst result out, for the Vedic MAC accumulator.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1.
// Once valid is raised, the source holds its data stable until the transfer.
// ready never depends combinationally on valid.
interface vedic_mac_accumulator_if #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_sat
  );

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_sat
  );
endinterface

// File: rtl/vedic_mac_accumulator.sv
// Sums a burst of 32-bit unsigned products into a saturating accumulator.
// The burst total, beat count and saturation flag are held until downstream accepts them.
module vedic_mac_accumulator #(
  parameter int ACC_W     = 48,
  parameter int CNT_W     = 8,
  parameter int MAX_BEATS = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  vedic_mac_accumulator_if.slave         bus,
  output logic                           dbg_state
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, res_acc_q, res_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, res_cnt_q, res_cnt_d;
  logic             sat_q, sat_d, res_sat_q, res_sat_d;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             sat_upd;
  logic             beat;
  logic             close;

  // The extra sum bit is the overflow flag; on overflow the accumulator pins at all ones.
  assign sum     = {1'b0, acc_q} + (ACC_W+1)'(bus.in_product);
  assign acc_upd = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign sat_upd = sat_q | sum[ACC_W];
  assign cnt_upd = cnt_q + 1'b1;
  assign beat    = bus.in_valid && (state_q == ACCUM);
  assign close   = bus.in_last || (cnt_upd == MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      res_acc_q <= '0;
      res_cnt_q <= '0;
      res_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      res_acc_q <= res_acc_d;
      res_cnt_q <= res_cnt_d;
      res_sat_q <= res_sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    res_acc_d = res_acc_q;
    res_cnt_d = res_cnt_q;
    res_sat_d = res_sat_q;
    if (clr) begin
      // Abort wins over a closing beat or a result handshake in the same cycle.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            if (close) begin
              res_acc_d = acc_upd;
              res_cnt_d = cnt_upd;
              res_sat_d = sat_upd;
              acc_d     = '0;
              cnt_d     = '0;
              sat_d     = 1'b0;
              state_d   = HOLD;
            end else begin
              acc_d = acc_upd;
              cnt_d = cnt_upd;
              sat_d = sat_upd;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_acc   = res_acc_q;
  assign bus.out_count = res_cnt_q;
  assign bus.out_sat   = res_sat_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Directed-vector bench for vedic_mac_accumulator: default, 33-bit and 4-beat instances.
module tb_vedic_mac_accumulator;

  logic clk;
  logic rst_n;
  logic clr;
  logic dbg_a, dbg_b, dbg_c;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  vedic_mac_accumulator_if #(.ACC_W(48), .CNT_W(8)) a_if ();
  vedic_mac_accumulator_if #(.ACC_W(33), .CNT_W(8)) b_if ();
  vedic_mac_accumulator_if #(.ACC_W(48), .CNT_W(8)) c_if ();

  vedic_mac_accumulator u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(a_if.slave), .dbg_state(dbg_a)
  );
  vedic_mac_accumulator #(.ACC_W(33)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b_if.slave), .dbg_state(dbg_b)
  );
  vedic_mac_accumulator #(.MAX_BEATS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(c_if.slave), .dbg_state(dbg_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [31:0] p, input logic last);
    case (w)
      0: begin a_if.in_valid = v; a_if.in_product = p; a_if.in_last = last; end
      1: begin b_if.in_valid = v; b_if.in_product = p; b_if.in_last = last; end
      default: begin c_if.in_valid = v; c_if.in_product = p; c_if.in_last = last; end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic r);
    case (w)
      0: a_if.out_ready = r;
      1: b_if.out_ready = r;
      default: c_if.out_ready = r;
    endcase
  endtask

  task automatic sample(input int w, output logic v, output logic rdy,
                        output logic [63:0] acc, output logic [63:0] cnt, output logic s);
    case (w)
      0: begin v = a_if.out_valid; rdy = a_if.in_ready; acc = 64'(a_if.out_acc);
               cnt = 64'(a_if.out_count); s = a_if.out_sat; end
      1: begin v = b_if.out_valid; rdy = b_if.in_ready; acc = 64'(b_if.out_acc);
               cnt = 64'(b_if.out_count); s = b_if.out_sat; end
      default: begin v = c_if.out_valid; rdy = c_if.in_ready; acc = 64'(c_if.out_acc);
               cnt = 64'(c_if.out_count); s = c_if.out_sat; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input int w, input logic [31:0] p, input logic last);
    logic v, rdy, s;
    logic [63:0] acc, cnt;
    int n;
    set_in(w, 1'b1, p, last);
    n = 0;
    sample(w, v, rdy, acc, cnt, s);
    while (!rdy && n < 20) begin
      @(negedge clk);
      sample(w, v, rdy, acc, cnt, s);
      n++;
    end
    if (!rdy) check("send_ready_timeout", 64'(rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, 32'h0, 1'b0);
  endtask

  // Expects the result on the current negedge (one cycle after the closing accept).
  task automatic expect_result(input int w, input string tag, input logic [63:0] e_acc,
                               input logic [63:0] e_cnt, input logic e_sat);
    logic v, rdy, s;
    logic [63:0] acc, cnt, q_acc;
    int n;
    exp_q.push_back(e_acc);
    n = 0;
    sample(w, v, rdy, acc, cnt, s);
    while (!v && n < 20) begin
      @(negedge clk);
      sample(w, v, rdy, acc, cnt, s);
      n++;
    end
    q_acc = exp_q.pop_front();
    check({tag, "_valid"}, 64'(v), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'd0);
    check({tag, "_acc"}, acc, q_acc);
    check({tag, "_count"}, cnt, e_cnt);
    check({tag, "_sat"}, 64'(s), 64'(e_sat));
    set_ordy(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(w, 1'b0);
    sample(w, v, rdy, acc, cnt, s);
    check({tag, "_drop_valid"}, 64'(v), 64'd0);
    check({tag, "_ready_back"}, 64'(rdy), 64'd1);
  endtask

  initial begin : main
    logic v, rdy, s;
    logic [63:0] acc, cnt;
    rst_n = 1'b0;
    clr   = 1'b0;
    for (int w = 0; w < 3; w++) begin
      set_in(w, 1'b0, 32'h0, 1'b0);
      set_ordy(w, 1'b0);
    end
    repeat (2) @(negedge clk);
    sample(0, v, rdy, acc, cnt, s);
    check("rst_valid", 64'(v), 64'd0);
    check("rst_ready", 64'(rdy), 64'd1);
    check("rst_acc", acc, 64'd0);
    check("rst_count", cnt, 64'd0);
    check("rst_sat", 64'(s), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-burst
    send(0, 32'h5, 1'b0);
    send(0, 32'h6, 1'b0);
    send(0, 32'h7, 1'b0);
    rst_n = 1'b0;
    #1;
    sample(0, v, rdy, acc, cnt, s);
    check("midrst_valid", 64'(v), 64'd0);
    check("midrst_ready", 64'(rdy), 64'd1);
    check("midrst_acc", acc, 64'd0);
    check("midrst_count", cnt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // three-beat burst, must start from zero after the reset
    send(0, 32'h0000_0001, 1'b0);
    send(0, 32'hFFFE_0001, 1'b0);
    sample(0, v, rdy, acc, cnt, s);
    check("b3_not_yet_valid", 64'(v), 64'd0);
    send(0, 32'h0000_0010, 1'b1);
    expect_result(0, "b3", 64'h0_FFFE_0012, 64'd3, 1'b0);

    // zero products count; single-beat burst
    send(0, 32'h0, 1'b0);
    send(0, 32'h0, 1'b1);
    expect_result(0, "zero", 64'd0, 64'd2, 1'b0);
    send(0, 32'h55, 1'b1);
    expect_result(0, "single", 64'h55, 64'd1, 1'b0);

    // backpressure with in_valid held high in HOLD
    send(0, 32'h100, 1'b0);
    send(0, 32'h200, 1'b1);
    set_in(0, 1'b1, 32'hDEAD, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sample(0, v, rdy, acc, cnt, s);
      check("bp_ready", 64'(rdy), 64'd0);
      check("bp_valid", 64'(v), 64'd1);
      check("bp_acc", acc, 64'h300);
      check("bp_count", cnt, 64'd2);
      @(negedge clk);
    end
    set_ordy(0, 1'b1);
    set_in(0, 1'b1, 32'h7, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_ordy(0, 1'b0);
    sample(0, v, rdy, acc, cnt, s);
    check("bp_release_valid", 64'(v), 64'd0);
    check("bp_release_ready", 64'(rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 32'h0, 1'b0);
    send(0, 32'h8, 1'b1);
    expect_result(0, "bp_next", 64'hF, 64'd2, 1'b0);

    // 33-bit accumulator saturation
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b1);
    expect_result(1, "w33_two", 64'h1_FFFF_FFFE, 64'd2, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b1);
    expect_result(1, "w33_sat", 64'h1_FFFF_FFFF, 64'd3, 1'b1);
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'h0, 1'b1);
    expect_result(1, "w33_sticky", 64'h1_FFFF_FFFF, 64'd4, 1'b1);
    send(1, 32'h5, 1'b1);
    expect_result(1, "w33_fresh", 64'h5, 64'd1, 1'b0);

    // forced close at MAX_BEATS=4
    send(2, 32'h10, 1'b0);
    send(2, 32'h10, 1'b0);
    send(2, 32'h10, 1'b0);
    sample(2, v, rdy, acc, cnt, s);
    check("max_after3_valid", 64'(v), 64'd0);
    send(2, 32'h10, 1'b0);
    expect_result(2, "max4", 64'h40, 64'd4, 1'b0);
    send(2, 32'h10, 1'b0);
    send(2, 32'h10, 1'b1);
    expect_result(2, "max_next", 64'h20, 64'd2, 1'b0);

    // clr against a closing beat
    send(0, 32'h11, 1'b0);
    set_in(0, 1'b1, 32'h22, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    set_in(0, 1'b0, 32'h0, 1'b0);
    sample(0, v, rdy, acc, cnt, s);
    check("clr_close_valid", 64'(v), 64'd0);
    check("clr_close_ready", 64'(rdy), 64'd1);
    send(0, 32'h3, 1'b1);
    expect_result(0, "clr_after", 64'h3, 64'd1, 1'b0);

    // clr while holding a result
    send(0, 32'h9, 1'b1);
    sample(0, v, rdy, acc, cnt, s);
    check("clr_hold_pre", 64'(v), 64'd1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    sample(0, v, rdy, acc, cnt, s);
    check("clr_hold_valid", 64'(v), 64'd0);
    check("clr_hold_ready", 64'(rdy), 64'd1);
    send(0, 32'h4, 1'b1);
    expect_result(0, "clr_hold_next", 64'h4, 64'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
